sdram_port_arbiter: RTL and testbench

Shares the single SDRAM controller command port between the camera capture write stream and one read requester (image processing/readout). Capture words arrive as valid-only pulses with no backpressure. They are buffered in a small FIFO and drained to the SDRAM whenever the controller is not busy. Reads are interleaved round-robin unless the FIFO nears full. Sits between the capture block and the SDRAM controller, in the posedge iCLK domain.

---
 rtl/sdram_arb_pkg.sv | 30 +++
 rtl/pixel_wr_fifo.sv | 52 +++++
 rtl/sdram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM port arbiter
package sdram_arb_pkg;

   // Default SDRAM geometry, shared with the capture block
   localparam int ADDR_W_DEF = 23;
   localparam int DATA_W_DEF = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_WR_CMD  = 2'd1;
   localparam logic [1:0] ST_RD_CMD  = 2'd2;
   localparam logic [1:0] ST_RD_WAIT = 2'd3;

   typedef enum logic {GNT_WR = 1'b0, GNT_RD = 1'b1} grant_t;

   typedef enum logic [1:0] {ARB_NONE = 2'd0, ARB_WR = 2'd1, ARB_RD = 2'd2} arb_t;

   // Writes win outright above the high-water mark, otherwise reads alternate with writes
   function automatic arb_t arbitrate(input logic hi_water, input logic rd_req,
                                      input grant_t last_grant, input logic empty);
      if (hi_water)
         return ARB_WR;
      else if (rd_req && (last_grant == GNT_WR || empty))
         return ARB_RD;
      else if (!empty)
         return ARB_WR;
      else
         return ARB_NONE;
   endfunction

endpackage

// File: rtl/pixel_wr_fifo.sv
// rtl/pixel_wr_fifo.sv - capture-word write buffer with combinational head
module pixel_wr_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 39
) (
   input  logic                       iCLK,
   input  logic                       iRST,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     level,
   output logic [WIDTH-1:0]           head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full    = (count == FULL_CNT);
      empty   = (count == '0);
      do_pop  = pop && !empty;
      // A full buffer still takes a word when the head leaves on the same edge
      do_push = push && (!full || do_pop);
      level   = count;
      head    = mem[rd_ptr];
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge iCLK) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - shares the SDRAM command port between capture writes and one reader
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int HI_WATER   = 12,
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic                          iCLK,
   input  logic                          iRST,
   input  logic                          iWr_valid,
   input  logic [ADDR_W-1:0]             iWr_addr,
   input  logic [DATA_W-1:0]             iWr_data,
   input  logic                          iRd_req,
   input  logic [ADDR_W-1:0]             iRd_addr,
   output logic                          oRd_grant,
   output logic [DATA_W-1:0]             oRd_data,
   output logic                          oRd_valid,
   output logic                          oCmd_valid,
   output logic                          oCmd_we,
   output logic [ADDR_W-1:0]             oCmd_addr,
   output logic [DATA_W-1:0]             oCmd_data,
   input  logic                          iCmd_busy,
   input  logic [DATA_W-1:0]             iSdram_rdata,
   input  logic                          iSdram_rvalid,
   input  logic                          iClr_ovf,
   output logic                          oOverflow,
   output logic [$clog2(FIFO_DEPTH):0]   oFifo_level
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]               state;
   grant_t                   last_grant;
   logic                     rd_req_q;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [LW-1:0]            fifo_level;
   logic [ADDR_W+DATA_W-1:0] fifo_head;
   logic                     fifo_pop;
   logic                     accept;
   logic                     launch;
   logic                     hi_water;
   arb_t                     next_arb;

   pixel_wr_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ADDR_W + DATA_W)
   ) u_fifo (
      .iCLK  (iCLK),
      .iRST  (iRST),
      .push  (iWr_valid),
      .pop   (fifo_pop),
      .wdata ({iWr_addr, iWr_data}),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level),
      .head  (fifo_head)
   );

   always_comb begin
      accept   = oCmd_valid && !iCmd_busy;
      hi_water = (fifo_level >= LW'(HI_WATER));
      launch   = (state == ST_IDLE) || (state == ST_WR_CMD && accept);
      // An accepted write counts as the latest grant for the decision made on that same edge
      next_arb = arbitrate(hi_water, rd_req_q,
                           (state == ST_WR_CMD) ? GNT_WR : last_grant, fifo_empty);
      fifo_pop = launch && (next_arb == ARB_WR);
      oFifo_level = fifo_level;
   end

   always_ff @(posedge iCLK or negedge iRST) begin
      if (!iRST) begin
         state      <= ST_IDLE;
         last_grant <= GNT_RD;
         rd_req_q   <= 1'b0;
         oRd_grant  <= 1'b0;
         oRd_data   <= '0;
         oRd_valid  <= 1'b0;
         oCmd_valid <= 1'b0;
         oCmd_we    <= 1'b0;
         oCmd_addr  <= '0;
         oCmd_data  <= '0;
         oOverflow  <= 1'b0;
      end else begin
         oRd_grant <= 1'b0;
         oRd_valid <= 1'b0;
         // Registered request; masked while a grant is in flight so a held request is not re-served
         rd_req_q  <= iRd_req && (state != ST_RD_CMD) && !oRd_grant;

         if (iWr_valid && fifo_full && !fifo_pop)
            oOverflow <= 1'b1;
         else if (iClr_ovf)
            oOverflow <= 1'b0;

         case (state)
            ST_IDLE, ST_WR_CMD: begin
               if (launch) begin
                  if (state == ST_WR_CMD) last_grant <= GNT_WR;
                  case (next_arb)
                     ARB_WR: begin
                        state      <= ST_WR_CMD;
                        oCmd_valid <= 1'b1;
                        oCmd_we    <= 1'b1;
                        {oCmd_addr, oCmd_data} <= fifo_head;
                     end
                     ARB_RD: begin
                        state      <= ST_RD_CMD;
                        oCmd_valid <= 1'b1;
                        oCmd_we    <= 1'b0;
                        oCmd_addr  <= iRd_addr;
                     end
                     default: begin
                        state      <= ST_IDLE;
                        oCmd_valid <= 1'b0;
                     end
                  endcase
               end
            end
            ST_RD_CMD: begin
               if (accept) begin
                  oRd_grant  <= 1'b1;
                  last_grant <= GNT_RD;
                  oCmd_valid <= 1'b0;
                  state      <= ST_RD_WAIT;
               end
            end
            default: begin
               if (iSdram_rvalid) begin
                  oRd_data  <= iSdram_rdata;
                  oRd_valid <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - scoreboard bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
   localparam int AW = 23;
   localparam int DW = 16;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } cmd_t;

   logic          iCLK = 1'b0;
   logic          iRST = 1'b0;
   logic          iWr_valid = 1'b0;
   logic [AW-1:0] iWr_addr = '0;
   logic [DW-1:0] iWr_data = '0;
   logic          iRd_req = 1'b0;
   logic [AW-1:0] iRd_addr = '0;
   logic          oRd_grant;
   logic [DW-1:0] oRd_data;
   logic          oRd_valid;
   logic          oCmd_valid;
   logic          oCmd_we;
   logic [AW-1:0] oCmd_addr;
   logic [DW-1:0] oCmd_data;
   logic          iCmd_busy = 1'b0;
   logic [DW-1:0] iSdram_rdata = '0;
   logic          iSdram_rvalid = 1'b0;
   logic          iClr_ovf = 1'b0;
   logic          oOverflow;
   logic [4:0]    oFifo_level;

   int   n_tests = 0;
   int   n_fail  = 0;
   cmd_t exp_cmd[$];
   logic [DW-1:0] exp_rd[$];

   sdram_port_arbiter dut (
      .iCLK          (iCLK),
      .iRST          (iRST),
      .iWr_valid     (iWr_valid),
      .iWr_addr      (iWr_addr),
      .iWr_data      (iWr_data),
      .iRd_req       (iRd_req),
      .iRd_addr      (iRd_addr),
      .oRd_grant     (oRd_grant),
      .oRd_data      (oRd_data),
      .oRd_valid     (oRd_valid),
      .oCmd_valid    (oCmd_valid),
      .oCmd_we       (oCmd_we),
      .oCmd_addr     (oCmd_addr),
      .oCmd_data     (oCmd_data),
      .iCmd_busy     (iCmd_busy),
      .iSdram_rdata  (iSdram_rdata),
      .iSdram_rvalid (iSdram_rvalid),
      .iClr_ovf      (iClr_ovf),
      .oOverflow     (oOverflow),
      .oFifo_level   (oFifo_level)
   );

   always #5 iCLK = ~iCLK;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   // Accepted commands and returned read data are checked against the scoreboard
   always @(negedge iCLK) begin
      if (iRST && oCmd_valid && !iCmd_busy) begin
         cmd_t e;
         n_tests++;
         if (exp_cmd.size() == 0) begin
            n_fail++;
            $display("FAIL cmd_unexpected: got we=%0b addr=%h data=%h, required none", oCmd_we, oCmd_addr, oCmd_data);
         end else begin
            e = exp_cmd.pop_front();
            if (oCmd_we !== e.we || oCmd_addr !== e.addr || (e.we && oCmd_data !== e.data)) begin
               n_fail++;
               $display("FAIL cmd_order: got we=%0b addr=%h data=%h, required we=%0b addr=%h data=%h",
                        oCmd_we, oCmd_addr, oCmd_data, e.we, e.addr, e.data);
            end
         end
      end
      if (iRST && oRd_valid) begin
         n_tests++;
         if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL rd_unexpected: got oRd_valid data=%h, required none", oRd_data);
         end else if (oRd_data !== exp_rd[0]) begin
            n_fail++;
            $display("FAIL rd_data: got %h, required %h", oRd_data, exp_rd.pop_front());
         end else begin
            void'(exp_rd.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      iWr_valid = 1'b1;
      iWr_addr  = a;
      iWr_data  = d;
      tick();
      iWr_valid = 1'b0;
   endtask

   task automatic exp_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cmd_t c;
      c.we = 1'b1; c.addr = a; c.data = d;
      exp_cmd.push_back(c);
   endtask

   task automatic exp_r(input logic [AW-1:0] a);
      cmd_t c;
      c.we = 1'b0; c.addr = a; c.data = '0;
      exp_cmd.push_back(c);
   endtask

   task automatic wait_grant(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         tick();
         if (oRd_grant) ok = 1'b1;
      end
      iRd_req = 1'b0;
   endtask

   task automatic wait_drain(output bit ok);
      ok = (exp_cmd.size() == 0);
      for (int i = 0; i < 200 && !ok; i++) begin
         tick();
         ok = (exp_cmd.size() == 0);
      end
      tick();
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_tests++;
      if ({oCmd_valid, oCmd_we, oCmd_addr, oCmd_data, oRd_grant, oRd_valid, oRd_data, oOverflow, oFifo_level} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b we=%0b addr=%h data=%h grant=%0b rvalid=%0b rdata=%h ovf=%0b lvl=%0d, required all 0",
                  oCmd_valid, oCmd_we, oCmd_addr, oCmd_data, oRd_grant, oRd_valid, oRd_data, oOverflow, oFifo_level);
      end
      iRST = 1'b1;
      tick();
   endtask

   task automatic test_single_write();
      exp_w(23'h000001, 16'hA55A);
      drive_wr(23'h000001, 16'hA55A);
      n_tests++;
      if (oCmd_valid !== 1'b0 || oFifo_level !== 5'd1) begin
         n_fail++;
         $display("FAIL single_after_push: got valid=%0b lvl=%0d, required valid=0 lvl=1", oCmd_valid, oFifo_level);
      end
      tick();
      n_tests++;
      if (oCmd_valid !== 1'b1 || oCmd_we !== 1'b1 || oCmd_addr !== 23'h000001 || oCmd_data !== 16'hA55A || oFifo_level !== 5'd0) begin
         n_fail++;
         $display("FAIL single_cmd: got valid=%0b we=%0b addr=%h data=%h lvl=%0d, required 1 1 000001 a55a 0",
                  oCmd_valid, oCmd_we, oCmd_addr, oCmd_data, oFifo_level);
      end
      tick();
      n_tests++;
      if (oCmd_valid !== 1'b0 || oFifo_level !== 5'd0) begin
         n_fail++;
         $display("FAIL single_done: got valid=%0b lvl=%0d, required 0 0", oCmd_valid, oFifo_level);
      end
   endtask

   task automatic test_burst();
      bit ok;
      for (int i = 0; i < 16; i++) begin
         exp_w(23'h010 + 23'(i), 16'h1111 * 16'(i) ^ 16'h00F0);
         drive_wr(23'h010 + 23'(i), 16'h1111 * 16'(i) ^ 16'h00F0);
      end
      wait_drain(ok);
      n_tests++;
      if (!ok || oOverflow !== 1'b0 || oFifo_level !== 5'd0) begin
         n_fail++;
         $display("FAIL burst_drain: got drained=%0b ovf=%0b lvl=%0d, required 1 0 0", ok, oOverflow, oFifo_level);
      end
   endtask

   task automatic test_overflow();
      bit ok;
      iCmd_busy = 1'b1;
      // One word sits in the command register, sixteen fill the buffer, the rest are dropped
      for (int w = 0; w < 17; w++) exp_w(23'h400 + 23'(w), 16'hC000 + 16'(w));
      for (int i = 0; i < 40; i++) begin
         iWr_valid = (i % 2 == 0);
         iWr_addr  = 23'h400 + 23'(i / 2);
         iWr_data  = 16'hC000 + 16'(i / 2);
         tick();
      end
      iWr_valid = 1'b0;
      n_tests++;
      if (oFifo_level !== 5'd16 || oOverflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_saturate: got lvl=%0d ovf=%0b, required 16 1", oFifo_level, oOverflow);
      end
      iCmd_busy = 1'b0;
      wait_drain(ok);
      n_tests++;
      if (!ok || oOverflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_drain: got drained=%0b ovf=%0b, required 1 1", ok, oOverflow);
      end
      iClr_ovf = 1'b1;
      tick();
      iClr_ovf = 1'b0;
      n_tests++;
      if (oOverflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_clear: got %0b, required 0", oOverflow);
      end
   endtask

   task automatic test_interleave();
      bit ok;
      iCmd_busy = 1'b1;
      exp_w(23'h050, 16'h0A01);
      exp_r(23'h100);
      exp_w(23'h051, 16'h0A02);
      exp_w(23'h052, 16'h0A03);
      drive_wr(23'h050, 16'h0A01);
      drive_wr(23'h051, 16'h0A02);
      drive_wr(23'h052, 16'h0A03);
      iRd_req  = 1'b1;
      iRd_addr = 23'h100;
      tick();
      tick();
      iCmd_busy = 1'b0;
      wait_grant(ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL interleave_grant: got no grant, required grant");
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_tests++;
         if (oCmd_valid !== 1'b0 || oFifo_level !== 5'd2) begin
            n_fail++;
            $display("FAIL interleave_rd_wait: got valid=%0b lvl=%0d, required 0 2", oCmd_valid, oFifo_level);
         end
      end
      exp_rd.push_back(16'h1234);
      iSdram_rdata  = 16'h1234;
      iSdram_rvalid = 1'b1;
      tick();
      iSdram_rvalid = 1'b0;
      wait_drain(ok);
      n_tests++;
      if (!ok || exp_rd.size() != 0) begin
         n_fail++;
         $display("FAIL interleave_drain: got drained=%0b rd_left=%0d, required 1 0", ok, exp_rd.size());
      end
   endtask

   task automatic test_hi_water();
      bit ok;
      iCmd_busy = 1'b1;
      exp_w(23'h600, 16'h6000);
      exp_w(23'h601, 16'h6001);
      exp_r(23'h200);
      for (int w = 2; w < 13; w++) exp_w(23'h600 + 23'(w), 16'h6000 + 16'(w));
      for (int w = 0; w < 13; w++) drive_wr(23'h600 + 23'(w), 16'h6000 + 16'(w));
      n_tests++;
      if (oFifo_level !== 5'd12) begin
         n_fail++;
         $display("FAIL hiwater_level: got %0d, required 12", oFifo_level);
      end
      iRd_req  = 1'b1;
      iRd_addr = 23'h200;
      tick();
      iCmd_busy = 1'b0;
      wait_grant(ok);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL hiwater_grant: got no grant, required grant");
      end
      tick();
      exp_rd.push_back(16'hBEEF);
      iSdram_rdata  = 16'hBEEF;
      iSdram_rvalid = 1'b1;
      tick();
      iSdram_rvalid = 1'b0;
      wait_drain(ok);
      n_tests++;
      if (!ok || exp_rd.size() != 0) begin
         n_fail++;
         $display("FAIL hiwater_drain: got drained=%0b rd_left=%0d, required 1 0", ok, exp_rd.size());
      end
   endtask

   task automatic test_reset_mid_read();
      bit ok;
      exp_r(23'h300);
      iRd_req  = 1'b1;
      iRd_addr = 23'h300;
      wait_grant(ok);
      for (int w = 0; w < 5; w++) drive_wr(23'h700 + 23'(w), 16'h7000 + 16'(w));
      n_tests++;
      if (!ok || oFifo_level !== 5'd5 || oCmd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_setup: got grant=%0b lvl=%0d valid=%0b, required 1 5 0", ok, oFifo_level, oCmd_valid);
      end
      #2;
      iRST = 1'b0;
      tick();
      n_tests++;
      if ({oCmd_valid, oCmd_we, oCmd_addr, oCmd_data, oRd_grant, oRd_valid, oRd_data, oOverflow, oFifo_level} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got valid=%0b lvl=%0d rvalid=%0b addr=%h, required all 0",
                  oCmd_valid, oFifo_level, oRd_valid, oCmd_addr);
      end
      iRST = 1'b1;
      tick();
      iSdram_rdata  = 16'hDEAD;
      iSdram_rvalid = 1'b1;
      tick();
      iSdram_rvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_tests++;
         if (oRd_valid !== 1'b0 || oCmd_valid !== 1'b0 || oFifo_level !== 5'd0) begin
            n_fail++;
            $display("FAIL rst_late_rvalid: got rvalid=%0b valid=%0b lvl=%0d, required 0 0 0", oRd_valid, oCmd_valid, oFifo_level);
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_burst();
      test_overflow();
      test_interleave();
      test_hi_water();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
